// File: rtl/uds_pkg.sv
// Shared widths and frame geometry for the UDS output serializer.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package uds_pkg;

    localparam int unsigned ITEM_W        = 32;
    localparam int unsigned ROW_W         = 256;
    localparam int unsigned ITEMS_PER_ROW = ROW_W / ITEM_W;
    localparam int unsigned ROW_CNT_W     = 4;

    // Rows per upsample frame; the odata bus carries 2*(A-8) items.
    function automatic int unsigned up_rows(input int unsigned a);
        return (a - 8) / 4;
    endfunction

    // Rows per downsample frame; only the low rows of the bus are meaningful.
    function automatic int unsigned dn_rows(input int unsigned a);
        return a / 16;
    endfunction

endpackage

// File: rtl/uds_frame_slot.sv
// One ping-pong frame slot: frame storage, mode bit, full flag and row mux.
// Latency: capture visible one cycle after wr_en; row mux is combinational.
// Backpressure: none inside; the parent decides when to write and release.
module uds_frame_slot
    import uds_pkg::*;
#(
    parameter int unsigned A = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [2*(A-8)*ITEM_W-1:0]  wr_data,
    input  logic                       wr_up,
    input  logic                       rel,
    input  logic [ROW_CNT_W-1:0]       row_idx,
    output logic                       full,
    output logic                       up,
    output logic [ROW_W-1:0]           row_data
);

    localparam int unsigned UP_ROWS = up_rows(A);

    logic [2*(A-8)*ITEM_W-1:0] data;

    // Capture a frame (a write in the releasing cycle wins, keeping the slot full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            up   <= 1'b0;
            full <= 1'b0;
        end else if (wr_en) begin
            data <= wr_data;
            up   <= wr_up;
            full <= 1'b1;
        end else if (rel) begin
            full <= 1'b0;
        end
    end

    // Select the 256-bit row addressed by row_idx; out-of-range indices read zero.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < int'(UP_ROWS); r++) begin
            if (row_idx == ROW_CNT_W'(r)) begin
                row_data = data[r*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/uds_out_serializer.sv
// Serializes UDS odata frames into 256-bit rows through a two-slot ping-pong buffer.
// Latency: first row presented one cycle after in_valid into an empty slot.
// Backpressure: rows wait on out_ready; a frame arriving with both slots held is dropped and flagged.
module uds_out_serializer
    import uds_pkg::*;
#(
    parameter int unsigned A = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*(A-8)*ITEM_W-1:0]  in_data,
    input  logic                       in_valid,
    input  logic                       in_up,
    output logic [ROW_W-1:0]           out_data,
    output logic [ROW_CNT_W-1:0]       out_row,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int unsigned UP_ROWS = up_rows(A);
    localparam int unsigned DN_ROWS = dn_rows(A);

    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [ROW_CNT_W-1:0] row_cnt;
    logic [ROW_CNT_W-1:0] last_idx;

    logic [1:0]           slot_full;
    logic [1:0]           slot_up;
    logic [ROW_W-1:0]     slot_row [2];
    logic [1:0]           slot_wr;
    logic [1:0]           slot_rel;

    logic                 xfer;
    logic                 last_xfer;
    logic                 wr_free;
    logic                 capture;
    logic                 drop;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        uds_frame_slot #(.A(A)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (slot_wr[i]),
            .wr_data  (in_data),
            .wr_up    (in_up),
            .rel      (slot_rel[i]),
            .row_idx  (row_cnt),
            .full     (slot_full[i]),
            .up       (slot_up[i]),
            .row_data (slot_row[i])
        );
    end

    // Final row index of the frame in the read slot depends on its stored mode.
    always_comb begin
        last_idx = slot_up[rd_ptr] ? ROW_CNT_W'(UP_ROWS - 1) : ROW_CNT_W'(DN_ROWS - 1);
    end

    assign out_valid = slot_full[rd_ptr];
    assign out_data  = slot_row[rd_ptr];
    assign out_row   = row_cnt;
    assign out_last  = out_valid && (row_cnt == last_idx);
    assign busy      = |slot_full;

    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && out_last;

    // The write slot is usable if empty or if its last row leaves this cycle.
    assign wr_free   = !slot_full[wr_ptr] || (last_xfer && (rd_ptr == wr_ptr));
    assign capture   = in_valid && wr_free;
    assign drop      = in_valid && !wr_free;

    // Route the capture strobe to the write slot and the release strobe to the read slot.
    always_comb begin
        slot_wr  = '0;
        slot_rel = '0;
        if (capture) begin
            slot_wr[wr_ptr] = 1'b1;
        end
        if (last_xfer) begin
            slot_rel[rd_ptr] = 1'b1;
        end
    end

    // Advance the row counter and read pointer on transfers, the write pointer on captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            row_cnt <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (last_xfer) begin
                row_cnt <= '0;
                rd_ptr  <= ~rd_ptr;
            end else if (xfer) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // Sticky drop flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/uds_out_serializer.md
UDS_OUT_SERIALIZER -- requirements
Module: uds_out_serializer

Interface
REQ-001 The block SHALL expose parameter A, default 7'd64, meaning UDS tile size in 32-bit items; legal values are 64 and 32.
REQ-002 The block SHALL expose localparams UP_ROWS = (A-8)/4 (14 for A=64) and DN_ROWS = A/16 (4 for A=64), meaning 256-bit rows per upsample or downsample frame.
REQ-003 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  2*(A-8)*32  UDS odata frame; row r occupies bits [r*256 +: 256].
REQ-006 in_valid  input  1  UDS odata_valid; a one-cycle frame strobe with no backpressure.
REQ-007 in_up  input  1  function_mode[1], sampled with in_valid; 1 = upsample frame, 0 = downsample frame.
REQ-008 out_data  output  256  current row: 8 items of 32 bits, item 0 in the LSBs.
REQ-009 out_row  output  4  index of the current row within its frame.
REQ-010 out_valid  output  1  a row is presented.
REQ-011 out_last  output  1  the presented row is the final row of its frame.
REQ-012 out_ready  input  1  the downstream consumer accepts the row.
REQ-013 busy  output  1  at least one frame slot is occupied.
REQ-014 overflow  output  1  sticky flag: a frame was dropped.
REQ-015 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-016 The block SHALL hold two frame slots (ping-pong). Each slot stores in_data, in_up and a full bit. A write pointer and a read pointer each toggle between slot 0 and slot 1.
REQ-017 When in_valid=1 and the write slot is free (or is being freed in this cycle), the block SHALL capture in_data and in_up into that slot at the clock edge, set its full bit, and toggle the write pointer.
REQ-018 When in_valid=1 and both slots are full with no slot freed in this cycle, the block SHALL drop the frame, set overflow, and leave all slots unchanged.
REQ-019 out_valid SHALL equal the full bit of the read slot, so first-row latency is one cycle after the in_valid cycle when the slot was empty.
REQ-020 out_data SHALL equal read slot data[row_cnt*256 +: 256], and out_row SHALL equal row_cnt.
REQ-021 Handshake: a row transfers in a cycle where out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_data, out_row and out_last SHALL remain stable.
REQ-022 On each transfer row_cnt SHALL increment. On the transfer of row N-1, where N is UP_ROWS or DN_ROWS selected by the stored in_up, the block SHALL clear the slot's full bit, reset row_cnt to 0, and toggle the read pointer.
REQ-023 out_last SHALL equal out_valid AND (row_cnt == N-1).
REQ-024 In downsample frames, rows DN_ROWS through UP_ROWS-1 of the stored data SHALL never be presented.
REQ-025 Simultaneous events:
- A capture in the same cycle as a last-row transfer SHALL succeed even if both slots were full.
- If overflow is set and clr_ovf is asserted in the same cycle, set SHALL win.
REQ-026 busy SHALL be the OR of both full bits.
REQ-027 out_valid SHALL never be asserted without a captured frame, and rows SHALL be presented in ascending order with frames in capture order.

Reset
REQ-028 While rst_n=0 the block SHALL asynchronously clear:
- all slot data and full bits, both pointers and row_cnt;
- out_valid, out_last, busy and overflow to 0;
- out_data and out_row to 0.
REQ-029 Reset asserted mid-frame SHALL discard all buffered frames, and no partial frame SHALL resume after release.

Structure
REQ-030 Package uds_pkg SHALL hold ITEM_W=32, ROW_W=256, the UP_ROWS/DN_ROWS functions of A, and the row-count width.
REQ-031 The implementation SHALL use one sub-module, uds_frame_slot, instantiated twice, containing frame storage, mode bit, full flag and row mux.

Verification
REQ-032 Single upsample frame, row r filled with value r, out_ready=1: 14 rows with out_row 0..13; out_valid rises one cycle after in_valid; out_last high only on row 13.
REQ-033 Downsample frame (in_up=0), rows 0..3 = 0xA0..0xA3: exactly 4 transfers; out_last on row 3; busy falls the next cycle.
REQ-034 Backpressure: out_ready low for 5 cycles on row 2: out_data and out_row hold at 2 throughout; no row is lost or duplicated.
REQ-035 Three back-to-back in_valid pulses with out_ready=0: frames 1 and 2 are buffered, frame 3 is dropped, and overflow=1. A later clr_ovf clears it, and frames 1 then 2 drain intact.
REQ-036 Both slots full, in_valid coincides with the last-row transfer: the new frame is captured and overflow stays 0.
REQ-037 rst_n pulsed low during row 7 of a frame: outputs are zero immediately; after release out_valid stays 0 until the next in_valid.
